// File: rtl/run_sequencer.sv
// run_sequencer
//   Sequences a small CPU through program load and execution.
//   After go, the host streams exactly 32 bytes into the shared 32x8 memory
//   at addresses 0..31. The CPU then runs with direct pass-through access to
//   that memory until it halts (DONE) or the watchdog expires (FAULT).
//   abort returns to IDLE from any state.
//
// Ports
//   clk, rst_n        clock; synchronous active-low reset
//   go, abort         start a load / return to IDLE
//   load_valid,
//   load_data[7:0]    host byte stream
//   load_ready        a host byte is accepted this cycle
//   cpu_addr[4:0],
//   cpu_we,
//   cpu_wdata[7:0]    CPU memory port, forwarded to the memory while running
//   cpu_halt          CPU has halted
//   cpu_start         CPU run enable
//   mem_addr[4:0],
//   mem_we,
//   mem_wdata[7:0]    shared memory port
//   busy, done,
//   timeout           status: LOAD/RUN, DONE, FAULT
//   cycles[15:0]      RUN cycle count of the current or last run
//   state_dbg[2:0]    current FSM state, for observation only
//
// Handshake: a host byte transfers on a cycle where load_valid and load_ready
// are both high. load_ready depends only on state and abort, never on
// load_valid, so the host may hold a byte indefinitely.
module run_sequencer #(
  parameter int WDOG_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic        abort,
  input  logic        load_valid,
  input  logic [7:0]  load_data,
  output logic        load_ready,
  input  logic [4:0]  cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_halt,
  output logic        cpu_start,
  output logic [4:0]  mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] cycles,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  localparam logic [15:0] WDOG_LIMIT = 16'(WDOG_CYCLES);

  state_t      state, state_nxt;
  logic [4:0]  ptr, ptr_nxt;
  logic [15:0] cyc, cyc_nxt;
  logic [15:0] cyc_inc;

  assign cyc_inc = cyc + 16'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr   <= 5'd0;
      cyc   <= 16'd0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cyc   <= cyc_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    cyc_nxt    = cyc;
    load_ready = 1'b0;
    cpu_start  = 1'b0;
    mem_addr   = 5'd0;
    mem_we     = 1'b0;
    mem_wdata  = 8'd0;

    case (state)
      ST_IDLE, ST_DONE, ST_FAULT: begin
        if (go) begin
          state_nxt = ST_LOAD;
          ptr_nxt   = 5'd0;
          cyc_nxt   = 16'd0;
        end
      end
      ST_LOAD: begin
        load_ready = 1'b1;
        mem_addr   = ptr;
        mem_wdata  = load_data;
        mem_we     = load_valid;
        if (load_valid) begin
          // ptr wraps to 0 naturally after the byte at address 31.
          ptr_nxt = ptr + 5'd1;
          if (ptr == 5'd31) begin
            state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        cpu_start = 1'b1;
        mem_addr  = cpu_addr;
        mem_we    = cpu_we;
        mem_wdata = cpu_wdata;
        // A halt takes priority over the watchdog and freezes the count.
        if (cpu_halt) begin
          state_nxt = ST_DONE;
        end else begin
          cyc_nxt = cyc_inc;
          if (cyc_inc == WDOG_LIMIT) begin
            state_nxt = ST_FAULT;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // abort overrides every transition and blocks writes and host transfers.
    if (abort) begin
      state_nxt  = ST_IDLE;
      ptr_nxt    = 5'd0;
      cyc_nxt    = 16'd0;
      mem_we     = 1'b0;
      load_ready = 1'b0;
    end
  end

  assign busy      = (state == ST_LOAD) || (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign timeout   = (state == ST_FAULT);
  assign cycles    = cyc;
  assign state_dbg = state;

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer
//   Directed scenarios followed by a randomized phase, checked every cycle
//   against a behavioural model of the sequencer kept in this file.
module tb_run_sequencer;

  localparam int WDOG = 20;

  logic        clk;
  logic        rst_n;
  logic        go;
  logic        abort;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_ready;
  logic [4:0]  cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_wdata;
  logic        cpu_halt;
  logic        cpu_start;
  logic [4:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [15:0] cycles;
  logic [2:0]  state_dbg;

  run_sequencer #(.WDOG_CYCLES(WDOG)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .go         (go),
    .abort      (abort),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .cpu_addr   (cpu_addr),
    .cpu_we     (cpu_we),
    .cpu_wdata  (cpu_wdata),
    .cpu_halt   (cpu_halt),
    .cpu_start  (cpu_start),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .cycles     (cycles),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase of the sequencer as seen from outside, plus how many bytes of the
  // current program have arrived and how many RUN cycles have elapsed.
  typedef enum int {M_IDLE, M_LOAD, M_RUN, M_DONE, M_FAULT} mphase_t;
  mphase_t m_phase = M_IDLE;
  int      m_loaded = 0;
  int      m_cycles = 0;
  bit      m_valid  = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase  <= M_IDLE;
      m_loaded <= 0;
      m_cycles <= 0;
      m_valid  <= 1'b1;
    end else if (m_valid) begin
      if (abort) begin
        m_phase  <= M_IDLE;
        m_loaded <= 0;
        m_cycles <= 0;
      end else if (m_phase == M_LOAD) begin
        if (load_valid) begin
          if (m_loaded + 1 == 32) begin
            m_phase  <= M_RUN;
            m_loaded <= 0;
          end else begin
            m_loaded <= m_loaded + 1;
          end
        end
      end else if (m_phase == M_RUN) begin
        if (cpu_halt) begin
          m_phase <= M_DONE;
        end else begin
          m_cycles <= m_cycles + 1;
          if (m_cycles + 1 == WDOG) m_phase <= M_FAULT;
        end
      end else if (go) begin
        m_phase  <= M_LOAD;
        m_loaded <= 0;
        m_cycles <= 0;
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [12:0] exp_q[$];
  logic [12:0] last_wr = 13'd0;
  int          load_writes = 0;
  int          ready_cycles = 0;

  always @(negedge clk) begin
    if (m_valid) begin
      bit          in_load;
      bit          in_run;
      bit          e_we;
      logic [4:0]  e_addr;
      logic [7:0]  e_data;
      logic [12:0] got;
      in_load = (m_phase == M_LOAD);
      in_run  = (m_phase == M_RUN);
      e_we    = !abort && ((in_load && load_valid) || (in_run && cpu_we));
      e_addr  = in_load ? 5'(m_loaded) : (in_run ? cpu_addr : 5'd0);
      e_data  = in_load ? load_data : (in_run ? cpu_wdata : 8'd0);

      check("load_ready", 32'(load_ready), 32'(in_load && !abort));
      check("cpu_start",  32'(cpu_start),  32'(in_run));
      check("mem_we",     32'(mem_we),     32'(e_we));
      check("mem_addr",   32'(mem_addr),   32'(e_addr));
      check("mem_wdata",  32'(mem_wdata),  32'(e_data));
      check("busy",       32'(busy),       32'(in_load || in_run));
      check("done",       32'(done),       32'(m_phase == M_DONE));
      check("timeout",    32'(timeout),    32'(m_phase == M_FAULT));
      check("cycles",     32'(cycles),     32'(m_cycles));

      if (in_load && load_valid && !abort) exp_q.push_back({e_addr, e_data});
      if (load_ready) ready_cycles++;
      if (load_ready && mem_we) begin
        got = {mem_addr, mem_wdata};
        load_writes++;
        last_wr = got;
        if (exp_q.size() == 0) begin
          check("load_wr_unexpected", 32'(got), 32'h1fff_ffff);
        end else begin
          check("load_wr", 32'(got), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cpu_addr  = 5'($urandom_range(0, 31));
    cpu_we    = 1'($urandom_range(0, 1));
    cpu_wdata = 8'($urandom_range(0, 255));
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic load_bytes(input int n);
    for (int k = 0; k < n; k++) begin
      load_valid = 1'b1;
      load_data  = 8'($urandom_range(0, 255));
      tick();
    end
    load_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int wr0;
  int rc0;

  initial begin
    rst_n = 1'b0; go = 1'b1; abort = 1'b1; load_valid = 1'b1; load_data = 8'hAA;
    cpu_addr = 5'd3; cpu_we = 1'b1; cpu_wdata = 8'h55; cpu_halt = 1'b1;
    repeat (3) tick();
    check("rst_cycles", 32'(cycles), 32'd0);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    rst_n = 1'b1; go = 1'b0; abort = 1'b0; load_valid = 1'b0; cpu_halt = 1'b0;
    tick();

    // Straight load of 0x00..0x1F.
    pulse_go();
    wr0 = load_writes;
    for (int k = 0; k < 32; k++) begin
      load_valid = 1'b1;
      load_data  = 8'(k);
      tick();
    end
    load_valid = 1'b0;
    check("t38_writes",  32'(load_writes - wr0), 32'd32);
    check("t38_last_wr", 32'(last_wr), 32'({5'd31, 8'd31}));
    check("t38_run",     32'(cpu_start), 32'd1);

    // Halt after 7 running cycles.
    cpu_halt = 1'b0;
    repeat (7) tick();
    cpu_halt = 1'b1;
    tick();
    cpu_halt = 1'b0;
    check("t40_done",   32'(done), 32'd1);
    check("t40_cycles", 32'(cycles), 32'd7);
    check("t40_start",  32'(cpu_start), 32'd0);

    // Load with load_valid toggling every cycle.
    pulse_go();
    wr0 = load_writes;
    rc0 = ready_cycles;
    for (int i = 0; i < 63; i++) begin
      load_valid = (i % 2 == 0);
      load_data  = 8'($urandom_range(0, 255));
      tick();
    end
    load_valid = 1'b0;
    check("t39_writes", 32'(load_writes - wr0), 32'd32);
    check("t39_cycles", 32'(ready_cycles - rc0), 32'd63);
    check("t39_run",    32'(cpu_start), 32'd1);

    // Watchdog expiry.
    repeat (19) tick();
    check("t41_pre", 32'(cpu_start), 32'd1);
    tick();
    check("t41_timeout", 32'(timeout), 32'd1);
    check("t41_cycles",  32'(cycles), 32'd20);

    // Halt on the last cycle before the watchdog.
    pulse_go();
    load_bytes(32);
    repeat (19) tick();
    cpu_halt = 1'b1;
    tick();
    cpu_halt = 1'b0;
    check("t41_halt_done",   32'(done), 32'd1);
    check("t41_halt_cycles", 32'(cycles), 32'd19);

    // Abort part-way through a load.
    pulse_go();
    load_bytes(10);
    abort = 1'b1;
    load_valid = 1'b1;
    tick();
    abort = 1'b0;
    wr0 = load_writes;
    repeat (3) tick();
    load_valid = 1'b0;
    check("t42_no_wr", 32'(load_writes - wr0), 32'd0);
    check("t42_idle",  32'(busy), 32'd0);
    pulse_go();
    load_valid = 1'b1;
    load_data  = 8'h5A;
    tick();
    check("t42_first_wr", 32'(last_wr), 32'({5'd0, 8'h5A}));
    load_bytes(31);
    check("t42_run", 32'(cpu_start), 32'd1);

    // Reset in the middle of a run.
    repeat (5) tick();
    check("t43_cycles5", 32'(cycles), 32'd5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t43_idle",   32'(busy), 32'd0);
    check("t43_cycles", 32'(cycles), 32'd0);
    check("t43_start",  32'(cpu_start), 32'd0);
    pulse_go();
    load_bytes(32);
    cpu_halt = 1'b1;
    tick();
    cpu_halt = 1'b0;
    check("t43_done", 32'(done), 32'd1);
    pulse_go();
    check("t43_reload_busy",   32'(busy), 32'd1);
    check("t43_reload_cycles", 32'(cycles), 32'd0);
    check("t43_reload_ready",  32'(load_ready), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      rst_n      = ($urandom_range(0, 199) != 0);
      go         = ($urandom_range(0, 7) == 0);
      abort      = ($urandom_range(0, 39) == 0);
      load_valid = ($urandom_range(0, 3) != 0);
      load_data  = 8'($urandom_range(0, 255));
      cpu_halt   = ($urandom_range(0, 11) == 0);
      tick();
    end
    rst_n = 1'b1; go = 1'b0; abort = 1'b0; load_valid = 1'b0; cpu_halt = 1'b0;
    tick();
    check("q_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 Parameter: WDOG_CYCLES, 1000, RUN-state cycle limit before fault; legal range 1..65535.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 go  input  1  start program load from IDLE, DONE or FAULT.
REQ-005 abort  input  1  return to IDLE from any state.
REQ-006 load_valid  input  1  host byte available on load_data.
REQ-007 load_data  input  8  host program byte.
REQ-008 load_ready  output  1  sequencer accepts a host byte this cycle.
REQ-009 cpu_addr  input  5  CPU memory address.
REQ-010 cpu_we  input  1  CPU memory write enable.
REQ-011 cpu_wdata  input  8  CPU memory write data.
REQ-012 cpu_halt  input  1  CPU has halted.
REQ-013 cpu_start  output  1  CPU run enable.
REQ-014 mem_addr  output  5  shared 32x8 memory address.
REQ-015 mem_we  output  1  shared memory write enable.
REQ-016 mem_wdata  output  8  shared memory write data.
REQ-017 busy  output  1  state is LOAD or RUN.
REQ-018 done  output  1  state is DONE.
REQ-019 timeout  output  1  state is FAULT.
REQ-020 cycles  output  16  RUN cycle count of the current/last run.

Function
REQ-021 States: IDLE, LOAD, RUN, DONE, FAULT; state register plus 5-bit load pointer ptr and 16-bit cycles counter.
REQ-022 All outputs are combinational functions of registered state and current inputs; no output registers beyond state/ptr/cycles.
REQ-023 IDLE: load_ready=0, cpu_start=0, mem_we=0, mem_addr=0, mem_wdata=0; go=1 -> LOAD, ptr<=0, cycles<=0.
REQ-024 LOAD: load_ready=1; mem_addr=ptr, mem_wdata=load_data, mem_we=load_valid; cpu_start=0.
REQ-025 LOAD accept = load_valid & load_ready; on accept ptr<=ptr+1; load_valid=0 cycles stall with no write and no ptr change.
REQ-026 LOAD: accept at ptr=31 -> RUN next cycle, ptr wraps to 0; exactly 32 bytes written, addresses 0..31 in order.
REQ-027 RUN: cpu_start=1, load_ready=0; mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata (pass-through, zero latency).
REQ-028 RUN, cpu_halt=1 -> DONE; cycles unchanged on that cycle.
REQ-029 RUN, cpu_halt=0 -> cycles<=cycles+1; if cycles+1 == WDOG_CYCLES -> FAULT.
REQ-030 Simultaneous cpu_halt=1 and watchdog condition: halt wins (DONE), cycles not incremented.
REQ-031 DONE/FAULT: cpu_start=0, mem_we=0, mem_addr=0, cycles held stable; go=1 -> LOAD, ptr<=0, cycles<=0.
REQ-032 go ignored in LOAD and RUN.
REQ-033 abort=1 in any state -> IDLE next cycle, overriding go, load accept and halt; mem_we forced 0 and load_ready forced 0 during the abort cycle; ptr and cycles cleared.
REQ-034 cycles never exceeds WDOG_CYCLES; no overflow possible.

Reset
REQ-035 rst_n=0 sampled at clk edge: state<=IDLE, ptr<=0, cycles<=0; overrides abort, go and all other inputs.
REQ-036 Outputs while in reset state: load_ready=0, cpu_start=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, timeout=0, cycles=0.
REQ-037 Reset mid-LOAD or mid-RUN discards progress; next go restarts load at address 0.

Verification (bench uses WDOG_CYCLES=20)
REQ-038 Reset, go pulse, 32 bytes 0x00..0x1F with load_valid held high -> mem writes addr k data k for k=0..31 on consecutive cycles, RUN entered the next cycle, cpu_start=1.
REQ-039 Load with load_valid toggling 1/0 every cycle -> 32 writes over 63 cycles, no write on stall cycles, ptr order preserved.
REQ-040 RUN, cpu_halt asserted after 7 non-halt cycles -> DONE, done=1, cycles=7, cpu_start=0.
REQ-041 RUN, cpu_halt never asserted -> FAULT after 20 RUN cycles, timeout=1, cycles=20; with cpu_halt=1 on the 20th cycle -> DONE, cycles=19.
REQ-042 abort at ptr=10 during LOAD -> IDLE next cycle, no further mem_we; subsequent go reloads from address 0.
REQ-043 rst_n=0 during RUN with cycles=5 -> next cycle IDLE, cycles=0, cpu_start=0; go after DONE -> LOAD with cycles=0.
